// File: rtl/rom_streamer.sv
// rom_streamer: reads len consecutive ROM words from start_addr and emits them on a valid/ready stream.
// Latency: first rom_r_en one cycle after an accepted start, first m_valid two cycles after it, then one word per cycle.
// Backpressure: m_ready low holds the 2-entry buffer head; reads pause while buffered + in-flight words would exceed 2.

// Small generic FIFO: registered storage, head word always visible on head_dat.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: none internally; the caller never pushes into a full FIFO or pops an empty one.
module rom_streamer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_vld,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    // Pointers wrap naturally, so DEPTH must be a power of two.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_vld) - CW'(pop_vld);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module rom_streamer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic              inflight_last;
    logic              done_q;
    logic [1:0]        occ;
    logic [DATA_W:0]   head_dat;
    logic              head_last;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              last_issue;
    logic [2:0]        slots;

    // A start is taken only in IDLE and not in the completion cycle.
    assign accept     = (state == IDLE) && start && !done_q;
    assign pop        = (occ != 2'd0) && m_ready;
    assign head_last  = head_dat[DATA_W];
    // Words that will occupy the buffer after this cycle if nothing new is read.
    assign slots      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue      = (state == RUN) && (remaining != '0) && (slots < 3'd2);
    assign last_issue = issue && (remaining == (ADDR_W+1)'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: RUN until the final read issues, DRAIN until the last beat leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && (len != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: read port follows the issue decision, stream port is the buffer head.
    always_comb begin
        busy     = (state != IDLE);
        done     = done_q;
        rom_r_en = issue;
        rom_addr = issue ? cur_addr : rom_addr_q;
        m_valid  = (occ != 2'd0);
        m_data   = head_dat[DATA_W-1:0];
        m_last   = (occ != 2'd0) && head_last;
    end

    // Address/count bookkeeping, in-flight tracking and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr      <= '0;
            rom_addr_q    <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            if (accept) begin
                cur_addr  <= start_addr;
                remaining <= len;
            end else if (issue) begin
                cur_addr   <= cur_addr + ADDR_W'(1);
                remaining  <= remaining - (ADDR_W+1)'(1);
                rom_addr_q <= cur_addr;
            end
            inflight      <= issue;
            inflight_last <= last_issue;
            done_q        <= (accept && (len == '0)) ||
                             ((state == DRAIN) && pop && head_last);
        end
    end

    // ROM data lands in the buffer the cycle after its read, tagged with its last flag.
    rom_streamer_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (inflight),
        .push_dat ({inflight_last, rom_rdata}),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (occ)
    );
endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: behavioural ROM, queue-based reference model, per-cycle compare process.
// Latency: model expects first read one cycle after an accepted start and done one cycle after the last beat.
// Backpressure: m_ready driven directly, held patterns or 50% random.
module tb_rom_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [10:0] len = '0;
    logic        busy;
    logic        done;
    logic        rom_r_en;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_rdata = '0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    bit rnd_ready = 1'b0;

    logic [7:0] rom [1024];

    // Reference model state
    logic [9:0] addr_q [$];
    logic [8:0] beat_q [$];
    int  cyc = 0;
    int  done_due = -1;
    int  accept_cyc = 0;
    int  issued = 0;
    int  popped = 0;
    bit  mdl_busy = 1'b0;
    bit  first_pending = 1'b0;
    bit  prev_stall = 1'b0;
    bit  exp_done;
    bit  busy_nxt;
    logic [9:0] a_tmp;

    rom_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_r_en   (rom_r_en),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one-cycle read latency
    always @(posedge clk) begin
        if (rom_r_en) rom_rdata <= rom[rom_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the queue model
    always @(negedge clk) begin
        if (rst) begin
            addr_q.delete();
            beat_q.delete();
            done_due = -1;
            issued = 0;
            popped = 0;
            mdl_busy = 1'b0;
            first_pending = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_done = (cyc == done_due);
            chk("done", done, exp_done);
            chk("busy", busy, mdl_busy);
            busy_nxt = mdl_busy;
            if (rom_r_en) begin
                chk("read_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) chk("rom_addr", rom_addr, addr_q.pop_front());
                issued++;
                if (first_pending) begin
                    chk("first_read_lat", cyc, accept_cyc + 1);
                    first_pending = 1'b0;
                end
            end
            if (prev_stall) chk("hold_valid", m_valid, 1);
            if (m_valid) begin
                chk("valid_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    chk("m_data", m_data, beat_q[0][7:0]);
                    chk("m_last", m_last, beat_q[0][8]);
                    if (m_ready) begin
                        popped++;
                        if (beat_q[0][8]) begin
                            done_due = cyc + 1;
                            busy_nxt = 1'b0;
                        end
                        void'(beat_q.pop_front());
                    end
                end
            end
            chk("outstanding_le2", (issued - popped) <= 2, 1);
            if (start && !mdl_busy && !exp_done) begin
                if (len == 0) begin
                    done_due = cyc + 1;
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
                        a_tmp = start_addr + 10'(i);
                        addr_q.push_back(a_tmp);
                        beat_q.push_back({i == int'(len) - 1, rom[a_tmp]});
                    end
                    busy_nxt = 1'b1;
                    accept_cyc = cyc;
                    first_pending = 1'b1;
                end
            end
            mdl_busy = busy_nxt;
            prev_stall = m_valid && !m_ready;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_cmd(input logic [9:0] a, input logic [10:0] l);
        tick();
        start = 1'b1;
        start_addr = a;
        len = l;
    endtask

    task automatic check_drained(input string nm);
        tick();
        @(negedge clk);
        #1;
        chk({nm, "_beats_left"}, beat_q.size(), 0);
        chk({nm, "_reads_left"}, addr_q.size(), 0);
    endtask

    task automatic wait_done(input string nm, input int limit, input bit noise);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (noise && busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                start_addr = 10'($urandom);
                len = 11'($urandom_range(1, 50));
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 1);
        check_drained(nm);
    endtask

    // Four-word stream with ready held high: exact cycle-by-cycle expectations
    task automatic directed4(input string nm, input logic [9:0] a,
                             input logic [9:0] ea [4], input logic [7:0] ed [4]);
        rnd_ready = 1'b0;
        m_ready = 1'b1;
        issue_cmd(a, 11'd4);
        for (int k = 1; k <= 7; k++) begin
            tick();
            @(negedge clk);
            chk({nm, "_ren"}, rom_r_en, (k <= 4));
            if (k <= 4) chk({nm, "_addr"}, rom_addr, ea[k-1]);
            chk({nm, "_valid"}, m_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) begin
                chk({nm, "_data"}, m_data, ed[k-3]);
                chk({nm, "_last"}, m_last, (k == 6));
            end
            chk({nm, "_done"}, done, (k == 7));
            chk({nm, "_busy"}, busy, (k <= 6));
        end
        check_drained(nm);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_ren"}, rom_r_en, 0);
        chk({nm, "_addr"}, rom_addr, 0);
        chk({nm, "_valid"}, m_valid, 0);
        chk({nm, "_data"}, m_data, 0);
        chk({nm, "_last"}, m_last, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] ea [4];
        logic [7:0] ed [4];
        bit seen;

        for (int i = 0; i < 1024; i++) rom[i] = 8'(i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Basic stream at 0x010
        ea = '{10'h010, 10'h011, 10'h012, 10'h013};
        ed = '{8'h10, 8'h11, 8'h12, 8'h13};
        directed4("t2", 10'h010, ea, ed);

        // Same stream, consumer stalls five cycles after first valid
        rnd_ready = 1'b0;
        m_ready = 1'b0;
        issue_cmd(10'h010, 11'd4);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        chk("t3_valid_seen", 32'(seen), 1);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                tick();
                @(negedge clk);
            end
            chk("t3_hold_valid", m_valid, 1);
            chk("t3_hold_data", m_data, 8'h10);
            chk("t3_ren_stopped", rom_r_en, 0);
        end
        tick();
        m_ready = 1'b1;
        wait_done("t3", 50, 1'b0);

        // Address wrap at the top of the ROM
        ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        ed = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        directed4("t5", 10'h3FE, ea, ed);

        // len=0, plus a start offered in the done cycle
        issue_cmd(10'h055, 11'd0);
        tick();
        start = 1'b1;
        start_addr = 10'h200;
        len = 11'd5;
        @(negedge clk);
        chk("t6_len0_done", done, 1);
        chk("t6_len0_busy", busy, 0);
        chk("t6_len0_ren", rom_r_en, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("t6_idle_busy", busy, 0);
            chk("t6_idle_done", done, 0);
            chk("t6_idle_valid", m_valid, 0);
        end

        // start while busy is ignored
        issue_cmd(10'h100, 11'd6);
        tick();
        tick();
        start = 1'b1;
        start_addr = 10'h300;
        len = 11'd9;
        wait_done("t6b", 50, 1'b0);

        // Randomized content and backpressure
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        rnd_ready = 1'b1;
        issue_cmd(10'($urandom), 11'd300);
        wait_done("t4", 2000, 1'b1);
        issue_cmd(10'($urandom), 11'd1100);
        wait_done("t4_wrap", 5000, 1'b0);
        for (int n = 0; n < 20; n++) begin
            issue_cmd(10'($urandom), 11'($urandom_range(0, 20)));
            wait_done("t4_rand", 500, 1'b1);
        end

        // Asynchronous reset in the middle of a stream
        rnd_ready = 1'b0;
        m_ready = 1'b1;
        issue_cmd(10'h020, 11'd8);
        tick();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("t1_async");
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("t1_no_done", done, 0);
            chk("t1_no_valid", m_valid, 0);
            chk("t1_no_read", rom_r_en, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_streamer.md
Name: rom_streamer

Overview:
Read-side master for a single-port synchronous ROM with 1-cycle read latency (rdata registered on the clk edge where r_en=1, held otherwise). On a start command it reads len consecutive words from start_addr and emits them on a valid/ready stream. A 2-entry output buffer absorbs the ROM latency, so throughput is one word per cycle under full backpressure-free operation. Sits between boot/firmware ROMs or lookup tables and stream consumers such as loaders and DMA.

Parameters:
DATA_W, 8, ROM word width and stream data width
ADDR_W, 10, ROM address width; addresses wrap modulo 2**ADDR_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  command pulse; sampled only in IDLE
start_addr  input  ADDR_W  first ROM address, captured with start
len  input  ADDR_W+1  word count, captured with start; 0 allowed
busy  output  1  high from cycle after accepted start until done cycle
done  output  1  one-cycle completion pulse
rom_r_en  output  1  ROM read enable
rom_addr  output  ADDR_W  ROM read address
rom_rdata  input  DATA_W  ROM read data, valid cycle after rom_r_en
m_valid  output  1  stream data valid
m_data  output  DATA_W  stream data
m_last  output  1  marks final word, qualified by m_valid
m_ready  input  1  consumer ready; beat transfers when m_valid&m_ready

Behaviour:
- Reset (async, any time): state IDLE, buffer and in-flight flag cleared, busy=0, done=0, rom_r_en=0, rom_addr=0, m_valid=0, m_data=0, m_last=0. Reset mid-stream aborts: no done, no further beats.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 captures start_addr/len. len=0 -> done=1 next cycle, stays IDLE, busy stays 0, no reads. len>0 -> RUN, busy=1 next cycle.
- start while busy or while done=1 is ignored.
- RUN: read issue rule per cycle: remaining>0 and (occupancy + inflight - pop) < 2, where occupancy = buffer entries (0..2), inflight = read issued last cycle, pop = m_valid&m_ready this cycle. On issue: rom_r_en=1, rom_addr=current address; address increments modulo 2**ADDR_W; remaining decrements. No issue: rom_r_en=0, rom_addr holds.
- First rom_r_en asserted the cycle after start accepted; first m_valid no earlier than 2 cycles after first rom_r_en... precisely: rom_rdata written to buffer in the cycle after issue, m_valid high the following cycle (data registered, buffer head drives m_data).
- remaining reaches 0 -> DRAIN.
- Buffer: 2-entry FIFO; push and pop in same cycle allowed; never overflows (guaranteed by issue rule); m_data and m_last held stable while m_valid=1 and m_ready=0.
- m_last=1 on the word that is the len-th read; tagged at issue time, carried through buffer.
- DRAIN: on handshake of the m_last beat -> IDLE; done=1 and busy=0 in the following cycle; done lasts exactly one cycle.
- Steady state with m_ready=1: one beat per cycle, rom_r_en continuous for len cycles.
- Address wrap: start_addr=2**ADDR_W-1 next address is 0. len > 2**ADDR_W legal; addresses keep wrapping.
- m_valid never depends combinationally on m_ready.

Test Plan:
1. Assert rst mid-cycle asynchronously -> all outputs 0 immediately, no done afterwards even if stream was active.
2. ROM rom[i]=i&0xFF, start_addr=0x010, len=4, m_ready=1 -> rom_r_en high 4 consecutive cycles at 0x010..0x013; m_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; m_last only on 0x13; done one cycle after that beat.
3. Same stream, m_ready=0 for 5 cycles after first m_valid -> at most 2 words buffered, rom_r_en stops, m_data held at 0x10; on release data 0x10..0x13 in order, no loss or duplication.
4. Random m_ready (50%), len=300 -> 300 beats, in-order sequential data, exactly one m_last and one done.
5. ADDR_W=10, start_addr=0x3FE, len=4 -> rom_addr 0x3FE,0x3FF,0x000,0x001; matching data.
6. len=0 -> done pulse next cycle, no rom_r_en, no m_valid; start pulsed while busy -> ignored, original stream completes unchanged.
